// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared instruction/data memory port: CPU (fixed priority) vs host/debug.
// Latency: host access completes 3 cycles after request when the CPU is idle; CPU path is combinational.
// Backpressure: host waits in PEND while the CPU strobes; optional ARB_HOLD_EN asserts cpu_hold after MAX_WAIT cycles.
module mem_bus_arbiter #(
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 16
) (
  input  logic          clock,
  input  logic          rst_,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  input  logic          cpu_halt,
  output logic          cpu_hold,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_busy,
  output logic          host_done,
  output logic [DW-1:0] host_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, PEND, ACC, DONE} state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          free;
  logic          host_own;

  // The port is free for the host whenever the CPU is not strobing or is halted.
  assign free     = (~cpu_rd & ~cpu_wr) | cpu_halt;
  assign host_own = (state_q == ACC) & free;

  // Next-state logic: latch the request once, wait for a free cycle, retry on collision.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (host_req) begin
          we_d    = host_we;
          addr_d  = host_addr;
          wdata_d = host_wdata;
          state_d = PEND;
        end
      end
      PEND: begin
        if (free) state_d = ACC;
      end
      ACC: begin
        if (free) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = DONE;
        end else begin
          // CPU grabbed the port this cycle; host strobes were suppressed, try again.
          state_d = PEND;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arbiter state and latched host request; reset aborts any in-flight access.
  always_ff @(posedge clock or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef ARB_HOLD_EN
  localparam logic [7:0] HOLD_AT = 8'(MAX_WAIT - 1);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       cpu_hold_q, cpu_hold_d;

  // Starvation counter: counts blocked PEND cycles and requests a CPU freeze at the threshold.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    cpu_hold_d = cpu_hold_q;
    if ((state_q == PEND) && !free && (wait_cnt_q != 8'hFF)) wait_cnt_d = wait_cnt_q + 8'd1;
    if (state_q == DONE) wait_cnt_d = 8'd0;
    if ((state_q == PEND) && (wait_cnt_q == HOLD_AT)) cpu_hold_d = 1'b1;
    if (state_d == DONE) cpu_hold_d = 1'b0;
  end

  // Starvation counter and hold request registers.
  always_ff @(posedge clock or negedge rst_) begin
    if (!rst_) begin
      wait_cnt_q <= 8'd0;
      cpu_hold_q <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

  assign cpu_hold = cpu_hold_q;
`else
  // Without the hold feature the host simply waits for an idle or halted CPU.
  assign cpu_hold = 1'b0;
`endif

  // Memory port mux: CPU passes straight through unless the host owns this ACC cycle.
  always_comb begin
    mem_rd    = cpu_rd;
    mem_wr    = cpu_wr;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (host_own) begin
      mem_rd    = ~we_q;
      mem_wr    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign host_busy  = (state_q == PEND) || (state_q == ACC);
  assign host_done  = (state_q == DONE);
  assign host_rdata = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter with a behavioural 32x8 memory and a host read-data scoreboard.
// Latency: checks the request-to-done timing of each scenario cycle by cycle.
// Backpressure: exercises CPU priority, ACC collisions and starvation handling (with or without ARB_HOLD_EN).
module tb_mem_bus_arbiter;

  logic       clock = 1'b0;
  logic       rst_  = 1'b0;
  logic       cpu_rd = 1'b0, cpu_wr = 1'b0, cpu_halt = 1'b0;
  logic [4:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic [7:0] cpu_rdata;
  logic       cpu_hold;
  logic       host_req = 1'b0, host_we = 1'b0;
  logic [4:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_busy, host_done;
  logic [7:0] host_rdata;
  logic       mem_rd, mem_wr;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int wr_cycles = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_last = 8'h00;

  // Behavioural memory: unwritten locations read as 8'h40 + address.
  logic [7:0] mem_arr [32];
  logic       mem_vld [32];

  mem_bus_arbiter #(.AW(5), .DW(8), .MAX_WAIT(4)) dut (
    .clock(clock), .rst_(rst_),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_halt(cpu_halt), .cpu_hold(cpu_hold),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_busy(host_busy), .host_done(host_done), .host_rdata(host_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] mem_peek(input logic [4:0] a);
    return mem_vld[a] ? mem_arr[a] : (8'h40 + {3'b000, a});
  endfunction

  assign mem_rdata = mem_peek(mem_addr);

  always @(posedge clock) begin
    if (mem_wr) begin
      mem_arr[mem_addr] <= mem_wdata;
      mem_vld[mem_addr] <= 1'b1;
    end
  end

  // Scoreboard monitor: every completion pops the expected host_rdata.
  always @(negedge clock) begin
    if (mem_wr) wr_cycles++;
    if (host_done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: host_done with no outstanding request");
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (host_rdata !== e) begin
          errors++;
          $display("FAIL sb_rdata: got %h expected %h", host_rdata, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Presents a one-cycle host request and scrambles the host inputs afterwards.
  task automatic host_issue(input logic we, input logic [4:0] a, input logic [7:0] d, input logic [7:0] rd_exp);
    host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
    if (we) sb.push_back(exp_last);
    else begin sb.push_back(rd_exp); exp_last = rd_exp; end
    step();
    host_req = 1'b0; host_we = ~we; host_addr = ~a; host_wdata = ~d;
  endtask

  task automatic test_reset();
    host_req = 1'b1; host_we = 1'b0; host_addr = 5'h1B;
    cpu_rd = 1'b1; cpu_addr = 5'h03;
    step(); step(); step();
    checks++;
    if ({cpu_hold, host_busy, host_done} !== 3'b000 || host_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: hold/busy/done=%b%b%b rdata=%h expected 000 00", cpu_hold, host_busy, host_done, host_rdata);
    end
    checks++;
    if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 5'h03) begin
      errors++;
      $display("FAIL reset_passthru: rd=%b wr=%b addr=%h expected 1 0 03", mem_rd, mem_wr, mem_addr);
    end
    cpu_rd = 1'b0; cpu_addr = 5'h00;
    rst_ = 1'b1;
    sb.push_back(8'h5B); exp_last = 8'h5B;
    step();
    host_req = 1'b0;
    checks++;
    if (host_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_accept: busy=%b expected 1", host_busy);
    end
    step(); step();
    checks++;
    if (host_done !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_done: done=%b expected 1", host_done);
    end
    step();
  endtask

  task automatic test_idle_write_read();
    int wr0;
    cpu_halt = 1'b1;
    wr0 = wr_cycles;
    host_issue(1'b1, 5'h1B, 8'hA5, 8'h00);
    checks++;
    if (host_busy !== 1'b1 || mem_wr !== 1'b0 || host_done !== 1'b0) begin
      errors++;
      $display("FAIL wr_pend: busy=%b wr=%b done=%b expected 1 0 0", host_busy, mem_wr, host_done);
    end
    step();
    checks++;
    if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 5'h1B || mem_wdata !== 8'hA5) begin
      errors++;
      $display("FAIL wr_acc: wr=%b rd=%b addr=%h wdata=%h expected 1 0 1b a5", mem_wr, mem_rd, mem_addr, mem_wdata);
    end
    step();
    checks++;
    if (host_done !== 1'b1 || host_busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_done: done=%b busy=%b expected 1 0", host_done, host_busy);
    end
    checks++;
    if (wr_cycles - wr0 != 1) begin
      errors++;
      $display("FAIL wr_pulse: mem_wr cycles=%0d expected 1", wr_cycles - wr0);
    end
    step();
    // Halted CPU with a stray read strobe must not block the host.
    cpu_rd = 1'b1; cpu_addr = 5'h02;
    host_issue(1'b0, 5'h1B, 8'h00, 8'hA5);
    step();
    checks++;
    if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 5'h1B) begin
      errors++;
      $display("FAIL rd_acc: rd=%b wr=%b addr=%h expected 1 0 1b", mem_rd, mem_wr, mem_addr);
    end
    step();
    checks++;
    if (host_done !== 1'b1 || host_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL rd_done: done=%b rdata=%h expected 1 a5", host_done, host_rdata);
    end
    cpu_rd = 1'b0; cpu_halt = 1'b0;
    step();
  endtask

  task automatic test_cpu_priority();
    logic bad = 1'b0;
    cpu_rd = 1'b1; cpu_addr = 5'h02;
    host_issue(1'b0, 5'h1D, 8'h00, 8'h5D);
    for (int i = 0; i < 6; i++) begin
      if (host_busy !== 1'b1 || host_done !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 5'h02) bad = 1'b1;
      step();
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL prio_pend: host disturbed CPU path or completed (busy=%b addr=%h) expected busy 1 addr 02", host_busy, mem_addr);
    end
    cpu_rd = 1'b0;
    step();
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 5'h1D || host_done !== 1'b0) begin
      errors++;
      $display("FAIL prio_acc: rd=%b addr=%h done=%b expected 1 1d 0", mem_rd, mem_addr, host_done);
    end
    step();
    checks++;
    if (host_done !== 1'b1) begin
      errors++;
      $display("FAIL prio_done: done=%b expected 1", host_done);
    end
    step();
  endtask

  task automatic test_collision();
    host_issue(1'b0, 5'h1B, 8'h00, 8'hA5);
    step();
    cpu_wr = 1'b1; cpu_addr = 5'h05; cpu_wdata = 8'h3C;
    #1;
    checks++;
    if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 5'h05 || mem_wdata !== 8'h3C) begin
      errors++;
      $display("FAIL col_cpu_wins: wr=%b rd=%b addr=%h wdata=%h expected 1 0 05 3c", mem_wr, mem_rd, mem_addr, mem_wdata);
    end
    step();
    cpu_wr = 1'b0;
    checks++;
    if (host_busy !== 1'b1 || host_done !== 1'b0 || mem_rd !== 1'b0 || mem_peek(5'h05) !== 8'h3C) begin
      errors++;
      $display("FAIL col_repend: busy=%b done=%b rd=%b mem5=%h expected 1 0 0 3c", host_busy, host_done, mem_rd, mem_peek(5'h05));
    end
    step();
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 5'h1B) begin
      errors++;
      $display("FAIL col_retry: rd=%b addr=%h expected 1 1b", mem_rd, mem_addr);
    end
    step();
    checks++;
    if (host_done !== 1'b1) begin
      errors++;
      $display("FAIL col_done: done=%b expected 1", host_done);
    end
    step();
  endtask

  task automatic test_starvation();
    cpu_rd = 1'b1; cpu_addr = 5'h07;
    host_issue(1'b0, 5'h1D, 8'h00, 8'h5D);
`ifdef ARB_HOLD_EN
    begin
      int cnt = 0;
      while (cpu_hold !== 1'b1 && cnt < 20) begin
        step();
        cnt++;
      end
      checks++;
      if (cnt != 4) begin
        errors++;
        $display("FAIL hold_rise: cpu_hold after %0d cycles expected 4", cnt);
      end
      cpu_rd = 1'b0;
      step();
      checks++;
      if (cpu_hold !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 5'h1D) begin
        errors++;
        $display("FAIL hold_acc: hold=%b rd=%b addr=%h expected 1 1 1d", cpu_hold, mem_rd, mem_addr);
      end
      step();
      checks++;
      if (host_done !== 1'b1 || cpu_hold !== 1'b0) begin
        errors++;
        $display("FAIL hold_clear: done=%b hold=%b expected 1 0", host_done, cpu_hold);
      end
    end
`else
    begin
      logic saw = 1'b0;
      for (int i = 0; i < 12; i++) begin
        if (host_done !== 1'b0 || cpu_hold !== 1'b0) saw = 1'b1;
        step();
      end
      checks++;
      if (saw !== 1'b0) begin
        errors++;
        $display("FAIL starve_wait: done or hold seen while CPU busy, flag=%b expected 0", saw);
      end
      cpu_halt = 1'b1;
      step();
      step();
      checks++;
      if (host_done !== 1'b1) begin
        errors++;
        $display("FAIL starve_halt_done: done=%b expected 1", host_done);
      end
    end
`endif
    cpu_rd = 1'b0; cpu_halt = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_access();
    cpu_halt = 1'b1;
    host_issue(1'b1, 5'h10, 8'h77, 8'h00);
    step();
    rst_ = 1'b0;
    #1;
    void'(sb.pop_back());
    exp_last = 8'h00;
    checks++;
    if (mem_wr !== 1'b0 || host_busy !== 1'b0 || host_rdata !== 8'h00) begin
      errors++;
      $display("FAIL rst_abort: wr=%b busy=%b rdata=%h expected 0 0 00", mem_wr, host_busy, host_rdata);
    end
    step();
    checks++;
    if (mem_peek(5'h10) !== 8'h50) begin
      errors++;
      $display("FAIL rst_no_commit: mem[10]=%h expected 50", mem_peek(5'h10));
    end
    rst_ = 1'b1; cpu_halt = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem_vld[i] = 1'b0;
    test_reset();
    test_idle_write_read();
    test_cpu_priority();
    test_collision();
    test_starvation();
    test_reset_mid_access();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d outstanding expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
